ahb3lite_memfill: RTL and testbench

AHB3LITE_MEMFILL -- requirements
Module: ahb3lite_memfill

---
 rtl/ahb3lite_memfill.sv | 163 ++++++++++++++++
 tb/tb_ahb3lite_memfill.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_memfill.sv
// AHB3-Lite master that fills a run of consecutive words with a selectable
// data pattern, reporting completion and slave ERROR responses.
module ahb3lite_memfill #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start_i,
    input  logic [HADDR_SIZE-1:0] base_addr_i,
    input  logic [15:0]           count_i,
    input  logic [1:0]            mode_i,
    input  logic [HDATA_SIZE-1:0] pattern_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int                    BYTES     = HDATA_SIZE / 8;
    localparam logic [HADDR_SIZE-1:0] ADDR_STEP = HADDR_SIZE'(BYTES);
    localparam logic [HADDR_SIZE-1:0] KB_MASK   = HADDR_SIZE'(1023);
    localparam logic [1:0]            HT_IDLE   = 2'b00;
    localparam logic [1:0]            HT_NONSEQ = 2'b10;
    localparam logic [1:0]            HT_SEQ    = 2'b11;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, ERR1, ERR2} state_t;

    state_t                  r_state;
    logic [HADDR_SIZE-1:0]   r_addr;
    logic [HDATA_SIZE-1:0]   r_wdata;
    logic [1:0]              r_trans;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic                    r_dataValid;
    logic [15:0]             r_remain;
    logic [15:0]             r_beatIdx;
    logic [1:0]              r_mode;
    logic [HDATA_SIZE-1:0]   r_pattern;

    logic [HADDR_SIZE-1:0]   w_nextAddr;
    logic                    w_kbBoundary;
    logic [HDATA_SIZE-1:0]   w_beatData;

    // A beat restarts the burst with NONSEQ whenever it crosses a 1 KB page;
    // wrapping to address 0 is covered because 0 is itself page aligned.
    assign w_nextAddr   = r_addr + ADDR_STEP;
    assign w_kbBoundary = ((w_nextAddr & KB_MASK) == '0);

    always_comb begin
        w_beatData = r_pattern;
        case (r_mode)
            2'b00:   w_beatData = r_pattern;
            2'b01:   w_beatData = r_pattern + HDATA_SIZE'(r_beatIdx);
            2'b10:   w_beatData = HDATA_SIZE'(r_addr);
            default: w_beatData = r_beatIdx[0] ? ~r_pattern : r_pattern;
        endcase
    end

    // Single-process FSM; write data is captured as each address phase is
    // accepted so it appears in the following (data phase) cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_trans     <= HT_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_dataValid <= 1'b0;
            r_remain    <= '0;
            r_beatIdx   <= '0;
            r_mode      <= '0;
            r_pattern   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (start_i && !r_done) begin
                        if (count_i != 16'd0) begin
                            r_state   <= RUN;
                            r_addr    <= base_addr_i;
                            r_trans   <= HT_NONSEQ;
                            r_remain  <= count_i;
                            r_beatIdx <= '0;
                            r_mode    <= mode_i;
                            r_pattern <= pattern_i;
                            r_busy    <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (HRESP && !HREADY && r_dataValid) begin
                        r_state <= ERR1;
                        r_trans <= HT_IDLE;
                    end else if (HREADY) begin
                        r_wdata     <= w_beatData;
                        r_dataValid <= 1'b1;
                        r_beatIdx   <= r_beatIdx + 16'd1;
                        r_remain    <= r_remain - 16'd1;
                        if (r_remain == 16'd1) begin
                            r_state <= DRAIN;
                            r_trans <= HT_IDLE;
                        end else begin
                            r_addr  <= w_nextAddr;
                            r_trans <= w_kbBoundary ? HT_NONSEQ : HT_SEQ;
                        end
                    end
                end
                DRAIN: begin
                    if (HRESP && !HREADY) begin
                        r_state <= ERR1;
                    end else if (HREADY) begin
                        r_state     <= IDLE;
                        r_done      <= 1'b1;
                        r_dataValid <= 1'b0;
                    end
                end
                ERR1: begin
                    if (HRESP && HREADY) begin
                        r_state     <= ERR2;
                        r_done      <= 1'b1;
                        r_error     <= 1'b1;
                        r_dataValid <= 1'b0;
                    end
                end
                ERR2: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign error_o   = r_error;
    assign HADDR     = r_addr;
    assign HWDATA    = r_wdata;
    assign HTRANS    = r_trans;
    assign HWRITE    = (r_trans != HT_IDLE);
    assign HSIZE     = 3'($clog2(BYTES));
    assign HBURST    = 3'b001;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb3lite_memfill.sv
// Randomised self-checking bench for ahb3lite_memfill: a slave-side monitor
// collects every accepted beat and compares it with an arithmetic model.
module tb_ahb3lite_memfill;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] count_i;
    logic [1:0]  mode_i;
    logic [31:0] pattern_i;
    logic        busy_o, done_o, error_o;
    logic [31:0] HADDR, HWDATA;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    int checks = 0;
    int errors = 0;

    ahb3lite_memfill #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start_i(start_i), .base_addr_i(base_addr_i),
        .count_i(count_i), .mode_i(mode_i), .pattern_i(pattern_i), .busy_o(busy_o),
        .done_o(done_o), .error_o(error_o), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expAddr(input logic [31:0] base, input int k);
        return base + 32'(k) * 32'd4;
    endfunction

    function automatic logic [31:0] expData(input logic [31:0] base, input int k,
                                            input logic [1:0] mode, input logic [31:0] pat);
        case (mode)
            2'b00:   return pat;
            2'b01:   return pat + 32'(k);
            2'b10:   return expAddr(base, k);
            default: return (k % 2 == 1) ? ~pat : pat;
        endcase
    endfunction

    function automatic logic [1:0] expTrans(input logic [31:0] base, input int k);
        logic [31:0] a;
        a = expAddr(base, k);
        return (k == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11;
    endfunction

    // One fill: errBeat/stallBeat/resetBeat select the data phase to disturb (-1 = none).
    task automatic applyStimulus(input logic [31:0] base, input int cnt, input logic [1:0] mode,
                                 input logic [31:0] pat, input int waitPct, input int stallBeat,
                                 input int errBeat, input int resetBeat);
        logic [31:0] gotAddr[$];
        logic [31:0] gotData[$];
        logic [1:0]  gotTrans[$];
        logic [31:0] prevAddr, prevData;
        logic [1:0]  prevTrans;
        int  latency, waits, errState, stallLeft, dataBeat, nextBeat, nA, nD, expLat;
        bit  doneSeen, errSeen, holdOk, busyEver, firstBusy, prevStall, writeOk, quiet, resetHit;
        latency = 0; waits = 0; errState = 0; stallLeft = 2; dataBeat = -1; nextBeat = 0;
        doneSeen = 0; errSeen = 0; holdOk = 1; busyEver = 0; firstBusy = 0; prevStall = 0;
        writeOk = 1; resetHit = 0;
        prevAddr = '0; prevData = '0; prevTrans = '0;

        @(negedge HCLK);
        start_i = 1'b1; base_addr_i = base; count_i = 16'(cnt); mode_i = mode; pattern_i = pat;
        HREADY = 1'b1; HRESP = 1'b0;
        for (int n = 1; n <= 3 * cnt + 200; n++) begin
            @(negedge HCLK);
            if (busy_o) busyEver = 1;
            if (n == 1) firstBusy = busy_o;
            if (prevStall && (HADDR !== prevAddr || HTRANS !== prevTrans || HWDATA !== prevData))
                holdOk = 0;
            if (HTRANS != 2'b00 && HWRITE !== 1'b1) writeOk = 0;
            if (done_o) begin
                doneSeen = 1; errSeen = error_o; latency = n;
                start_i = 1'b1; count_i = 16'd5;
                break;
            end
            prevStall = 0;
            if (errState == 1) begin
                checkOutput("errIdleTrans", HTRANS, 2'b00);
                HREADY = 1'b1; HRESP = 1'b1; errState = 2; dataBeat = -1;
            end else if (dataBeat >= 0 && dataBeat == errBeat && errState == 0) begin
                HREADY = 1'b0; HRESP = 1'b1; errState = 1;
            end else if (dataBeat >= 0 && dataBeat == resetBeat) begin
                resetHit = 1;
                break;
            end else if (dataBeat >= 0 && dataBeat == stallBeat && stallLeft > 0) begin
                HREADY = 1'b0; HRESP = 1'b0; stallLeft--; prevStall = 1;
            end else begin
                HRESP = 1'b0; HREADY = ($urandom_range(99) >= waitPct); prevStall = !HREADY;
            end
            if (!HREADY) waits++;
            prevAddr = HADDR; prevTrans = HTRANS; prevData = HWDATA;
            start_i = ($urandom_range(3) == 0); base_addr_i = $urandom & ~32'h3;
            count_i = 16'($urandom_range(1, 20)); mode_i = 2'($urandom); pattern_i = $urandom;
            if (HREADY && !HRESP) begin
                if (dataBeat >= 0) begin
                    gotData.push_back(HWDATA);
                    dataBeat = -1;
                end
                if (HTRANS != 2'b00) begin
                    gotAddr.push_back(HADDR); gotTrans.push_back(HTRANS);
                    dataBeat = nextBeat; nextBeat++;
                end
            end
        end

        if (resetHit) begin
            HRESET = 1'b1; start_i = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
            #1;
            checkOutput("rstAddr", HADDR, 32'h0);
            checkOutput("rstData", HWDATA, 32'h0);
            checkOutput("rstCtl", {HTRANS, HWRITE, busy_o, done_o, error_o}, 6'b0);
            @(negedge HCLK);
            HRESET = 1'b0;
            quiet = 1;
            for (int i = 0; i < 6; i++) begin
                @(negedge HCLK);
                if (done_o || error_o || busy_o || HTRANS != 2'b00) quiet = 0;
            end
            checkOutput("rstQuiet", quiet, 1'b1);
            return;
        end

        checkOutput("doneSeen", doneSeen, 1'b1);
        @(negedge HCLK);
        start_i = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        if (!doneSeen) return;
        if (errBeat >= 0) begin
            nA = errBeat + 1; nD = errBeat;
        end else begin
            nA = cnt; nD = cnt;
            expLat = (cnt == 0) ? 1 : cnt + 2 + waits;
            checkOutput("latency", 64'(latency), 64'(expLat));
        end
        checkOutput("errorFlag", errSeen, errBeat >= 0);
        checkOutput("addrBeats", 64'(gotAddr.size()), 64'(nA));
        checkOutput("dataBeats", 64'(gotData.size()), 64'(nD));
        for (int k = 0; k < gotAddr.size() && k < nA; k++) begin
            checkOutput($sformatf("addr[%0d]", k), gotAddr[k], expAddr(base, k));
            checkOutput($sformatf("trans[%0d]", k), gotTrans[k], expTrans(base, k));
        end
        for (int k = 0; k < gotData.size() && k < nD; k++)
            checkOutput($sformatf("data[%0d]", k), gotData[k], expData(base, k, mode, pat));
        checkOutput("stallHold", holdOk, 1'b1);
        checkOutput("hwrite", writeOk, 1'b1);
        checkOutput("busyEver", busyEver, cnt != 0);
        if (cnt != 0) checkOutput("busyFirst", firstBusy, 1'b1);
        quiet = 1;
        for (int i = 0; i < 3; i++) begin
            if (done_o || error_o || busy_o || HTRANS != 2'b00) quiet = 0;
            @(negedge HCLK);
        end
        checkOutput("postIdle", quiet, 1'b1);
    endtask

    initial begin
        logic [31:0] base;
        int          cnt;
        bit          quiet;
        HRESET = 1'b1; start_i = 1'b0; base_addr_i = '0; count_i = '0; mode_i = '0;
        pattern_i = '0; HREADY = 1'b1; HRESP = 1'b0;
        #1;
        checkOutput("rstAddr0", HADDR, 32'h0);
        checkOutput("rstData0", HWDATA, 32'h0);
        checkOutput("rstCtl0", {HTRANS, HWRITE, busy_o, done_o, error_o}, 6'b0);
        repeat (2) @(negedge HCLK);
        HRESET = 1'b0;
        checkOutput("constBus", {HSIZE, HBURST, HPROT, HMASTLOCK}, {3'd2, 3'b001, 4'b0011, 1'b0});
        quiet = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            if (done_o || busy_o || HTRANS != 2'b00) quiet = 0;
        end
        checkOutput("idleAfterReset", quiet, 1'b1);

        applyStimulus(32'h100, 4, 2'b01, 32'h10, 0, -1, -1, -1);
        applyStimulus(32'h100, 4, 2'b01, 32'h10, 0, 2, -1, -1);
        applyStimulus(32'h3F8, 4, 2'b10, 32'h0, 0, -1, -1, -1);
        applyStimulus(32'h2000, 8, 2'b11, 32'hA5A5_0F0F, 0, -1, 1, -1);
        applyStimulus(32'h40, 0, 2'b00, 32'h1234, 0, -1, -1, -1);
        applyStimulus(32'h800, 8, 2'b01, 32'h55, 0, -1, -1, 3);
        applyStimulus(32'h900, 2, 2'b00, 32'hCAFE_F00D, 0, -1, -1, -1);
        applyStimulus(32'hFFFF_FFF0, 8, 2'b10, 32'h0, 20, -1, -1, -1);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(2))
                0:       base = $urandom & ~32'h3;
                1:       base = 32'h400 * 32'($urandom_range(1, 8)) - 32'(4 * $urandom_range(1, 6));
                default: base = 32'h0 - 32'(4 * $urandom_range(1, 8));
            endcase
            cnt = $urandom_range(1, 40);
            if (i % 4 == 3)
                applyStimulus(base, cnt, 2'($urandom), $urandom, $urandom_range(0, 40), -1,
                              $urandom_range(0, cnt - 1), -1);
            else
                applyStimulus(base, cnt, 2'($urandom), $urandom, $urandom_range(0, 40), -1, -1, -1);
        end

        applyStimulus(32'h0001_0000, 65535, 2'b01, 32'hFFFF_0000, 0, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
